// File: rtl/nanorv32_irq_pkg.sv
// Shared constants for the nanorv32 interrupt controller: register map,
// FSM state encoding and the valid-line mask helper.
package nanorv32_irq_pkg;

  localparam int NIRQ_MAX = 8;

  localparam logic [1:0] IRQ_ENABLE  = 2'd0;
  localparam logic [1:0] IRQ_EDGE    = 2'd1;
  localparam logic [1:0] IRQ_PENDING = 2'd2;
  localparam logic [1:0] IRQ_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } irq_state_e;

  // Bits [n-1:0] set: lines that physically exist.
  function automatic logic [NIRQ_MAX-1:0] line_mask(input int n);
    logic [NIRQ_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < NIRQ_MAX; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/nanorv32_irq_prio_enc.sv
// Combinational 8-to-3 priority encoder; the lowest set index wins.
module nanorv32_irq_prio_enc (
  input  logic [7:0] req_i,
  output logic       valid_o,
  output logic [2:0] id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Scan downwards so the lowest set bit is the final assignment.
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) id_o = 3'(i);
    end
  end

endmodule

// File: rtl/nanorv32_irq_ctrl.sv
// Interrupt controller: latches/masks peripheral IRQs, picks the lowest index
// and hands it to the core through a req/ack/eoi handshake.
module nanorv32_irq_ctrl
  import nanorv32_irq_pkg::*;
#(
  parameter int         NIRQ     = 8,
  parameter logic [7:0] EDGE_RST = 8'h00
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irqs,
  input  logic            reg_wr,
  input  logic [1:0]      reg_addr,
  input  logic [7:0]      reg_wdata,
  output logic [7:0]      reg_rdata,
  output logic            irq_req,
  output logic [2:0]      irq_id,
  input  logic            irq_ack,
  input  logic            irq_eoi
);

  localparam logic [NIRQ_MAX-1:0] LINE_MASK = line_mask(NIRQ);

  irq_state_e state_q, state_d;
  logic [7:0] enable_q, enable_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] pend_edge_q, pend_edge_d;
  logic [7:0] irqs_q;
  logic [2:0] irq_id_q, irq_id_d;

  logic [7:0] irqs_ext, rise, pending, active, ack_clr, wr_clr;
  logic       any_active;
  logic [2:0] prio_id;
  logic       ack_take;

  always_comb begin
    irqs_ext = '0;
    for (int i = 0; i < NIRQ; i++) irqs_ext[i] = irqs[i];
  end

  assign rise     = irqs_ext & ~irqs_q;
  assign pending  = ((edge_q & pend_edge_q) | (~edge_q & irqs_ext)) & LINE_MASK;
  assign active   = pending & enable_q;
  assign ack_take = (state_q == ST_REQ) && irq_ack;

  nanorv32_irq_prio_enc u_prio (
    .req_i   (active),
    .valid_o (any_active),
    .id_o    (prio_id)
  );

  // Register writes and pending-edge bookkeeping; a new edge beats any clear.
  assign ack_clr = ack_take ? ((8'b1 << irq_id_q) & edge_q) : 8'h00;
  assign wr_clr  = (reg_wr && reg_addr == IRQ_PENDING) ? reg_wdata : 8'h00;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    enable_d    = enable_q;
    edge_d      = edge_q;
    pend_edge_d = ((pend_edge_q & ~(ack_clr | wr_clr)) | (edge_q & rise)) & LINE_MASK;
    if (reg_wr && reg_addr == IRQ_ENABLE) enable_d = reg_wdata & LINE_MASK;
    if (reg_wr && reg_addr == IRQ_EDGE)   edge_d   = reg_wdata & LINE_MASK;
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      ST_IDLE: if (any_active) begin
        irq_id_d = prio_id;
        state_d  = ST_REQ;
      end
      ST_REQ:  if (irq_ack) state_d = ST_SVC;
      ST_SVC:  if (irq_eoi) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      enable_q    <= '0;
      edge_q      <= EDGE_RST & LINE_MASK;
      pend_edge_q <= '0;
      irqs_q      <= '0;
      irq_id_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      pend_edge_q <= pend_edge_d;
      irqs_q      <= irqs_ext;
      irq_id_q    <= irq_id_d;
    end
  end

  assign irq_req = (state_q == ST_REQ);
  assign irq_id  = irq_id_q;

  always_comb begin
    unique case (reg_addr)
      IRQ_ENABLE:  reg_rdata = enable_q;
      IRQ_EDGE:    reg_rdata = edge_q;
      IRQ_PENDING: reg_rdata = pending;
      default:     reg_rdata = {3'b000, state_q, irq_id_q};
    endcase
  end

endmodule

// File: tb/tb_nanorv32_irq_ctrl.sv
// Self-checking bench for nanorv32_irq_ctrl: directed scenarios plus random
// traffic, all compared each cycle against a behavioural model.
module tb_nanorv32_irq_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] irqs   = '0;
  logic       reg_wr = 1'b0;
  logic [1:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic       irq_ack = 1'b0;
  logic       irq_eoi = 1'b0;
  logic [7:0] reg_rdata;
  logic       irq_req;
  logic [2:0] irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  nanorv32_irq_ctrl #(.NIRQ(8), .EDGE_RST(8'h00)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .irqs      (irqs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: state 0=idle, 1=requesting, 2=in service.
  int         m_state;
  logic [7:0] m_en, m_edge, m_pend, m_prev;
  int         m_id;
  int         n_state;
  logic [7:0] n_en, n_edge, n_pend;
  int         n_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_id = 0;
    m_en = '0; m_edge = '0; m_pend = '0; m_prev = '0;
  endtask

  function automatic logic [7:0] m_pending();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_edge[i] ? m_pend[i] : irqs[i];
    return p;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_en;
      2'd1:    return m_edge;
      2'd2:    return m_pending();
      default: return 8'(m_state * 8 + m_id);
    endcase
  endfunction

  task automatic model_next();
    logic [7:0] act;
    int first;
    act = m_pending() & m_en;
    first = -1;
    for (int i = 7; i >= 0; i--) if (act[i]) first = i;
    n_state = m_state; n_id = m_id; n_en = m_en; n_edge = m_edge;
    for (int i = 0; i < 8; i++) begin
      bit set_i, clr_i;
      set_i = m_edge[i] && irqs[i] && !m_prev[i];
      clr_i = (reg_wr && reg_addr == 2'd2 && reg_wdata[i]) ||
              (m_state == 1 && irq_ack && m_edge[i] && i == m_id);
      n_pend[i] = set_i ? 1'b1 : (clr_i ? 1'b0 : m_pend[i]);
    end
    if (m_state == 0 && first >= 0) begin n_state = 1; n_id = first; end
    else if (m_state == 1 && irq_ack) n_state = 2;
    else if (m_state == 2 && irq_eoi) n_state = 0;
    if (reg_wr && reg_addr == 2'd0) n_en = reg_wdata;
    if (reg_wr && reg_addr == 2'd1) n_edge = reg_wdata;
  endtask

  task automatic step();
    model_next();
    @(posedge clk_in);
    m_state = n_state; m_id = n_id; m_en = n_en; m_edge = n_edge;
    m_pend = n_pend; m_prev = irqs;
    #1;
    check("irq_req", irq_req, (m_state == 1));
    check("irq_id", irq_id, m_id);
    check("reg_rdata", reg_rdata, m_read(reg_addr));
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    step();
    reg_wr = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_req", irq_req, 1'b0);
    rd_check("rst_status", 2'd3, 8'h00);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Level mode on line 1: one-cycle latency, re-request after eoi.
    wr_reg(2'd0, 8'h03);
    irqs = 8'h02;
    step();
    check("lvl_req", irq_req, 1'b1);
    check("lvl_id", irq_id, 3'd1);
    pulse_ack();
    check("lvl_ack_drop", irq_req, 1'b0);
    pulse_eoi();
    step();
    check("lvl_rereq", irq_req, 1'b1);
    check("lvl_rereq_id", irq_id, 3'd1);
    irqs = 8'h00;
    pulse_ack();
    pulse_eoi();
    step();

    // Edge mode on line 0: two-cycle latency, ack clears pending.
    wr_reg(2'd1, 8'h01);
    wr_reg(2'd0, 8'h01);
    irqs = 8'h01;
    step();
    irqs = 8'h00;
    check("edge_not_yet", irq_req, 1'b0);
    rd_check("edge_pend", 2'd2, 8'h01);
    step();
    check("edge_req", irq_req, 1'b1);
    check("edge_id", irq_id, 3'd0);
    pulse_ack();
    rd_check("edge_pend_clr", 2'd2, 8'h00);
    pulse_eoi();
    step();
    check("edge_idle", irq_req, 1'b0);

    // Simultaneous level requests: lowest index first.
    wr_reg(2'd1, 8'h00);
    wr_reg(2'd0, 8'h03);
    irqs = 8'h03;
    step();
    check("prio_id0", irq_id, 3'd0);
    irqs = 8'h02;
    pulse_ack();
    pulse_eoi();
    step();
    check("prio_id1", irq_id, 3'd1);
    irqs = 8'h00;
    pulse_ack();
    pulse_eoi();

    // Edge set coinciding with ack wins over the ack clear.
    wr_reg(2'd1, 8'h01);
    wr_reg(2'd0, 8'h01);
    irqs = 8'h01; step(); irqs = 8'h00; step();
    check("sw_req", irq_req, 1'b1);
    irqs = 8'h01; irq_ack = 1'b1; step(); irq_ack = 1'b0; irqs = 8'h00;
    rd_check("sw_pend_kept", 2'd2, 8'h01);
    irqs = 8'h01; step(); irqs = 8'h00;
    pulse_eoi();
    step();
    check("sw_rereq", irq_req, 1'b1);
    check("sw_rereq_id", irq_id, 3'd0);
    pulse_ack();
    pulse_eoi();

    // Disabled lines never request; level pending cannot be cleared.
    wr_reg(2'd1, 8'h00);
    wr_reg(2'd0, 8'h00);
    irqs = 8'hFF;
    step(); step();
    check("dis_req", irq_req, 1'b0);
    wr_reg(2'd2, 8'hFF);
    rd_check("lvl_pend_stays", 2'd2, 8'hFF);

    // Asynchronous reset while requesting.
    wr_reg(2'd0, 8'h10);
    step();
    check("pre_rst_req", irq_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_req", irq_req, 1'b0);
    rd_check("async_rst_status", 2'd3, 8'h00);
    irqs = 8'h00;
    @(negedge clk_in);
    rst_n = 1'b1;
    rd_check("rst_enable", 2'd0, 8'h00);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      irqs      = 8'($urandom);
      irq_ack   = ($urandom_range(0, 2) == 0);
      irq_eoi   = ($urandom_range(0, 2) == 0);
      reg_wr    = ($urandom_range(0, 5) == 0);
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = 8'($urandom);
      step();
    end
    reg_wr = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
